// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared constants for the EX-stage ALU share arbiter: ALUOp encodings
//   seen on alu_op, requester id encodings for resp_id, and a small helper
//   that turns a one-hot grant into a requester id.
//   No ports (package).

package alu_share_arbiter_pkg;

   localparam int ALU_OP_W = 5;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   // ALUOp codes understood by the shared EX-stage ALU.
   localparam alu_op_t ALU_ADD  = 5'd0;
   localparam alu_op_t ALU_SUB  = 5'd1;
   localparam alu_op_t ALU_SLL  = 5'd2;
   localparam alu_op_t ALU_SLT  = 5'd3;
   localparam alu_op_t ALU_SLTU = 5'd4;
   localparam alu_op_t ALU_XOR  = 5'd5;
   localparam alu_op_t ALU_SRL  = 5'd6;
   localparam alu_op_t ALU_SRA  = 5'd7;
   localparam alu_op_t ALU_OR   = 5'd8;
   localparam alu_op_t ALU_AND  = 5'd9;
   localparam alu_op_t ALU_BEQ  = 5'd10;
   localparam alu_op_t ALU_BNE  = 5'd11;
   localparam alu_op_t ALU_BLT  = 5'd12;
   localparam alu_op_t ALU_BGE  = 5'd13;
   localparam alu_op_t ALU_BLTU = 5'd14;
   localparam alu_op_t ALU_BGEU = 5'd15;

   // resp_id decode: which requester a response belongs to.
   localparam logic ARB_ID_PIPE = 1'b0;
   localparam logic ARB_ID_AUX  = 1'b1;

   // Map a one-hot (or empty) two-bit grant onto a requester id.
   // An empty grant maps to the pipeline id; callers only use the result
   // when some grant is active.
   function automatic logic grant_to_id(input logic [1:0] grant);
      return grant[1] ? ARB_ID_AUX : ARB_ID_PIPE;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way request arbiter producing a one-hot grant.
//   Build option: ALU_ARB_FIXED_PRIO_EN
//     undefined - round-robin: on contention the requester that did not
//                 win last time is granted.
//     defined   - fixed priority: requester 0 always wins contention;
//                 last_grant is accepted but has no effect.
//   Ports:
//     valid[1:0]  in   request valids (bit N = requester N)
//     enable      in   grants allowed this cycle (response slot free)
//     last_grant  in   requester id of the most recent acceptance
//     grant[1:0]  out  one-hot grant, all zero when disabled or idle

module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       enable,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
               grant = 2'b01;
`else
               // Favour whoever did not win the previous acceptance.
               grant = last_grant ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares the single combinational EX-stage ALU between the main pipeline
//   (requester 0) and an auxiliary helper (requester 1). One request is
//   granted per cycle; the ALU outputs are captured into a one-entry
//   response register drained through a valid/ready consumer port.
//   A drain and a new capture may happen on the same edge, so the block
//   sustains one operation per cycle.
//   Build option: ALU_ARB_FIXED_PRIO_EN (see rr_arb2) selects fixed
//   priority for requester 0 instead of round-robin.
//   Parameters:
//     DATA_W  operand/result width (must match the ALU datapath)
//     TAG_W   opaque requester tag width
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     reqN_valid/ready         requester N handshake
//     reqN_op/a/b/tag          requester N ALUOp, operands, tag
//     alu_op/a/b               operands driven to the shared ALU
//     alu_result, alu_branch   combinational ALU outputs
//     resp_valid/ready         response handshake
//     resp_data/branch/id/tag  captured result, branch flag, owner, tag

module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [4:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [TAG_W-1:0]  req0_tag,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [4:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [TAG_W-1:0]  req1_tag,

   output logic [4:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_branch,

   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_branch,
   output logic              resp_id,
   output logic [TAG_W-1:0]  resp_tag
);

   logic             slot_free;
   logic [1:0]       grant;
   logic             accept;
   logic             grant_id;
   logic             last_grant;
   logic [TAG_W-1:0] grant_tag;

   // The slot is reusable when empty or when its content leaves this cycle.
   assign slot_free = !resp_valid || resp_ready;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .enable     (slot_free),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Grant is already gated by slot_free and implies the matching valid.
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = |grant;
   assign grant_id   = grant_to_id(grant);

   // Operand mux: idle and stalled cycles present zeros to the ALU so the
   // shared datapath does not toggle on stale operands.
   always_comb begin
      alu_op    = '0;
      alu_a     = '0;
      alu_b     = '0;
      grant_tag = '0;
      if (grant[0]) begin
         alu_op    = req0_op;
         alu_a     = req0_a;
         alu_b     = req0_b;
         grant_tag = req0_tag;
      end else if (grant[1]) begin
         alu_op    = req1_op;
         alu_a     = req1_a;
         alu_b     = req1_b;
         grant_tag = req1_tag;
      end
   end

   // Response register and round-robin pointer. The pointer resets to the
   // auxiliary id so the pipeline wins the first contended cycle, and it
   // only moves on a real acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_branch <= 1'b0;
         resp_id     <= ARB_ID_PIPE;
         resp_tag    <= '0;
         last_grant  <= ARB_ID_AUX;
      end else begin
         if (accept) begin
            resp_valid  <= 1'b1;
            resp_data   <= alu_result;
            resp_branch <= alu_branch;
            resp_id     <= grant_id;
            resp_tag    <= grant_tag;
            last_grant  <= grant_id;
         end else if (resp_ready) begin
            resp_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [4:0]        req0_op, req1_op;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [TAG_W-1:0]  req0_tag, req1_tag;
   logic [4:0]        alu_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic              alu_branch;
   logic              resp_valid, resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_branch, resp_id;
   logic [TAG_W-1:0]  resp_tag;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              br;
      logic              id;
      logic [TAG_W-1:0]  tag;
   } resp_t;

   resp_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  m_valid;
   logic  m_last;
   logic  last_g0, last_g1;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_branch(alu_branch),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_branch(resp_branch), .resp_id(resp_id), .resp_tag(resp_tag)
   );

   // Reference ALU. Compare ops yield data 0 and the compare outcome; other
   // ops report Branch_ALU high so a captured 1 is distinguishable from reset.
   function automatic logic [DATA_W:0] alu_ref(input logic [4:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] d;
      logic              br;
      d  = '0;
      br = 1'b1;
      case (op)
         ALU_ADD:  d = a + b;
         ALU_SUB:  d = a - b;
         ALU_SLL:  d = a << b[4:0];
         ALU_SLT:  d = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: d = {31'd0, a < b};
         ALU_XOR:  d = a ^ b;
         ALU_SRL:  d = a >> b[4:0];
         ALU_SRA:  d = $signed(a) >>> b[4:0];
         ALU_OR:   d = a | b;
         ALU_AND:  d = a & b;
         ALU_BEQ:  br = (a == b);
         ALU_BNE:  br = (a != b);
         ALU_BLT:  br = ($signed(a) < $signed(b));
         ALU_BGE:  br = ($signed(a) >= $signed(b));
         ALU_BLTU: br = (a < b);
         ALU_BGEU: br = (a >= b);
         default:  begin d = '0; br = 1'b0; end
      endcase
      return {d, br};
   endfunction

   always_comb {alu_result, alu_branch} = alu_ref(alu_op, alu_a, alu_b);

   task automatic fail(input string name, input logic [68:0] obs, input logic [68:0] exp);
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   // One clock of the directed sequence: compare handshakes, ALU drive and
   // response against the bench model at the falling edge, then advance.
   task automatic step();
      logic sf, g0, g1, prio0, was_rst;
      resp_t e;
      @(negedge clk);
      sf = !m_valid || resp_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
      prio0 = 1'b1;
`else
      prio0 = (m_last == 1'b1);
`endif
      g0 = sf && req0_valid && (!req1_valid || prio0);
      g1 = sf && req1_valid && !g0;
      checks++; if (req0_ready !== g0) fail("req0_ready", req0_ready, g0);
      checks++; if (req1_ready !== g1) fail("req1_ready", req1_ready, g1);
      checks++; if (resp_valid !== m_valid) fail("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
         if (sb.size() == 0) begin
            checks++; fail("sb_nonempty", 0, 1);
         end else begin
            e = sb[0];
            checks++; if (resp_data !== e.data) fail("resp_data", resp_data, e.data);
            checks++; if (resp_branch !== e.br) fail("resp_branch", resp_branch, e.br);
            checks++; if (resp_id !== e.id) fail("resp_id", resp_id, e.id);
            checks++; if (resp_tag !== e.tag) fail("resp_tag", resp_tag, e.tag);
         end
      end
      if (!g0 && !g1) begin
         checks++;
         if ({alu_op, alu_a, alu_b} !== 69'd0) fail("alu_idle_zero", {alu_op, alu_a, alu_b}, 69'd0);
      end
      if (m_valid && resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (g0) begin
         e.data = alu_ref(req0_op, req0_a, req0_b) >> 1;
         e.br   = alu_ref(req0_op, req0_a, req0_b) & 1;
         e.id   = ARB_ID_PIPE;
         e.tag  = req0_tag;
         sb.push_back(e);
         m_last = 1'b0;
      end else if (g1) begin
         e.data = alu_ref(req1_op, req1_a, req1_b) >> 1;
         e.br   = alu_ref(req1_op, req1_a, req1_b) & 1;
         e.id   = ARB_ID_AUX;
         e.tag  = req1_tag;
         sb.push_back(e);
         m_last = 1'b1;
      end
      m_valid = g0 || g1 || (m_valid && !resp_ready);
      last_g0 = g0;
      last_g1 = g1;
      was_rst = rst;
      @(posedge clk);
      #1;
      if (was_rst) begin
         sb.delete();
         m_valid = 1'b0;
         m_last  = 1'b1;
      end
   endtask

   task automatic set0(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
   endtask

   task automatic set1(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
   endtask

   initial begin
      logic prev_g1;
      rst = 1'b1;
      resp_ready = 1'b1;
      set0(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
      m_valid = 1'b0;
      m_last  = 1'b1;
      last_g0 = 1'b0;
      last_g1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      checks++; if (resp_valid !== 1'b0) fail("rst_resp_valid", resp_valid, 1'b0);
      checks++; if (resp_data !== 32'd0) fail("rst_resp_data", resp_data, 32'd0);
      checks++; if (resp_branch !== 1'b0) fail("rst_resp_branch", resp_branch, 1'b0);
      checks++; if (resp_id !== 1'b0) fail("rst_resp_id", resp_id, 1'b0);
      checks++; if (resp_tag !== 4'd0) fail("rst_resp_tag", resp_tag, 4'd0);

      // Single op: ADD 5+7, tag 3
      set0(1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3);
      step();
      set0(1'b0, ALU_ADD, 32'd5, 32'd7, 4'd3);
      checks++; if (resp_valid !== 1'b1) fail("single_valid", resp_valid, 1'b1);
      checks++; if (resp_data !== 32'd12) fail("single_data", resp_data, 32'd12);
      checks++; if (resp_branch !== 1'b1) fail("single_branch", resp_branch, 1'b1);
      checks++; if (resp_id !== 1'b0) fail("single_id", resp_id, 1'b0);
      checks++; if (resp_tag !== 4'd3) fail("single_tag", resp_tag, 4'd3);
      step();
      step();

      // Reset so contention starts from the reset pointer.
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Contention: four accepted ops, grants must alternate 0,1,0,1
      set0(1'b1, ALU_SUB, 32'd10, 32'd4, 4'd1);
      set1(1'b1, ALU_XOR, 32'h0000_00F0, 32'h0000_000F, 4'd2);
      prev_g1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
`ifdef ALU_ARB_FIXED_PRIO_EN
         checks++; if (last_g0 !== 1'b1) fail("fixed_grant0", last_g0, 1'b1);
`else
         checks++; if (last_g1 !== ~prev_g1) fail("rr_alternate", last_g1, ~prev_g1);
`endif
         prev_g1 = last_g1;
         if (resp_id == ARB_ID_AUX) begin
            checks++; if (resp_data !== 32'h0000_00FF) fail("rr_aux_data", resp_data, 32'h0000_00FF);
         end else begin
            checks++; if (resp_data !== 32'd6) fail("rr_pipe_data", resp_data, 32'd6);
         end
      end

      // Backpressure: response held for 3 cycles with both requesters valid
      resp_ready = 1'b0;
      repeat (3) step();
      resp_ready = 1'b1;
      step();
      checks++; if ((last_g0 | last_g1) !== 1'b1) fail("bp_release_accept", last_g0 | last_g1, 1'b1);
      set0(1'b0, ALU_SUB, 32'd10, 32'd4, 4'd1);
      set1(1'b0, ALU_XOR, 32'h0000_00F0, 32'h0000_000F, 4'd2);
      step();

      // Branch compares on requester 1
      set1(1'b1, ALU_BLT, 32'hFFFF_FFFF, 32'd1, 4'd5);
      step();
      checks++; if (resp_branch !== 1'b1) fail("blt_branch", resp_branch, 1'b1);
      checks++; if (resp_data !== 32'd0) fail("blt_data", resp_data, 32'd0);
      checks++; if (resp_id !== 1'b1) fail("blt_id", resp_id, 1'b1);
      set1(1'b1, ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 4'd6);
      step();
      checks++; if (resp_branch !== 1'b0) fail("bltu_branch", resp_branch, 1'b0);
      set1(1'b0, ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 4'd6);
      step();

      // Reset mid-flight: pending response with consumer stalled
      set1(1'b1, ALU_OR, 32'h1234_0000, 32'h0000_5678, 4'd7);
      step();
      set1(1'b0, ALU_OR, 32'h1234_0000, 32'h0000_5678, 4'd7);
      resp_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (resp_valid !== 1'b0) fail("midrst_valid", resp_valid, 1'b0);
      resp_ready = 1'b1;
      set0(1'b1, ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd8);
      set1(1'b1, ALU_SLL, 32'd1, 32'd4, 4'd9);
      #1;
      checks++; if (req0_ready !== 1'b1) fail("midrst_first_grant0", req0_ready, 1'b1);
      step();
      set0(1'b0, ALU_AND, 32'd0, 32'd0, 4'd0);
      set1(1'b0, ALU_SLL, 32'd0, 32'd0, 4'd0);
      step();

      // Idle cycles must not rotate the pointer
      set1(1'b1, ALU_SRA, 32'h8000_0000, 32'd3, 4'hA);
      step();
      set1(1'b0, ALU_SRA, 32'h8000_0000, 32'd3, 4'hA);
      repeat (5) step();
      set0(1'b1, ALU_SLT, 32'hFFFF_FFFE, 32'd2, 4'hB);
      set1(1'b1, ALU_BGEU, 32'd3, 32'd3, 4'hC);
      #1;
      checks++; if (req0_ready !== 1'b1) fail("idle_no_rotate_grant0", req0_ready, 1'b1);
      step();
      set0(1'b0, ALU_SLT, 32'd0, 32'd0, 4'd0);

      // Randomised traffic honouring the hold-until-ready rule
      for (int i = 0; i < 80; i++) begin
         if (!req0_valid || last_g0)
            set0(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                 $urandom, $urandom, 4'($urandom));
         if (!req1_valid || last_g1)
            set1(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                 $urandom, $urandom, 4'($urandom));
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Drain
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0);
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0);
      resp_ready = 1'b1;
      repeat (3) step();
      checks++; if (sb.size() !== 0) fail("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational EX-stage ALU between two requesters: port 0 is the main pipeline EX issue; port 1 is an auxiliary requester such as an address-gen or branch-check helper.
- Each requester uses a valid/ready handshake.
- The arbiter grants one request per cycle, drives the ALU operands and captures the ALU outputs into a one-entry response register.
- The response register is drained by a valid/ready consumer.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU datapath.
- TAG_W, 4, opaque requester tag carried through unchanged.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  5  ALUOp code (`ADD..`BGEU from defines.v)
- req0_a  in  DATA_W  rs1 operand
- req0_b  in  DATA_W  rs2 operand
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same widths and meaning, requester 1
- alu_op  out  5  to ALU ALUOp
- alu_a  out  DATA_W  to ALU rs1_data
- alu_b  out  DATA_W  to ALU rs2_data
- alu_result  in  DATA_W  from ALU rd_data
- alu_branch  in  1  from ALU Branch_ALU
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer takes the response
- resp_data  out  DATA_W  captured ALU result
- resp_branch  out  1  captured branch flag
- resp_id  out  1  which requester (0/1) the response belongs to
- resp_tag  out  TAG_W  tag of that request

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - resp_valid=0, resp_data=0, resp_branch=0, resp_id=0, resp_tag=0.
  - RR pointer last_grant=1, so requester 0 has priority in the first cycle.
- Slot free:
  - slot_free = !resp_valid || resp_ready.
  - A drain and a new capture in the same cycle is allowed, giving full throughput of 1 op/cycle.
- Grant, combinational:
  - If !slot_free, no grant and both readys are 0.
  - Else if exactly one valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
- Handshake:
  - reqN_ready = slot_free && grant_N. At most one ready is high per cycle.
  - Ready may depend on valid.
  - A requester must hold valid and its payload stable until ready. The arbiter does not check this.
- ALU drive:
  - alu_op/a/b carry the granted requester's fields.
  - With no grant, they carry all zeros. Results are not captured on those cycles.
- Capture, on a clock edge with any reqN_valid && reqN_ready:
  - resp_data <= alu_result; resp_branch <= alu_branch; resp_id <= N; resp_tag <= reqN_tag; resp_valid <= 1.
  - last_grant <= N.
- Drain: resp_valid && resp_ready && no capture → resp_valid <= 0. Data fields hold their last value.
- Latency: exactly 1 cycle from acceptance edge to resp_valid=1.
- Backpressure: resp_valid && !resp_ready → response fields frozen, no grants, ALU operands zero.
- Reset mid-operation: a pending response is discarded and the pointer is restored. Requesters must re-present.
- last_grant updates only on an actual acceptance. Idle cycles do not rotate it.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention. last_grant is still tracked but ignored for arbitration.
- Undefined: round-robin as above. Under continuous contention, a requester waits at most 1 accepted op.

Decomposition:
- ALUOp codes stay in defines.v.
- Add to defines.v: `ARB_ID_PIPE (1'b0) and `ARB_ID_AUX (1'b1) for resp_id decode.
- Natural sub-module: rr_arb2 (inputs: two valids, enable, last_grant; output: one-hot grant). It holds the round-robin vs fixed-priority selection under the macro.
- Operand mux and response register stay in the top module.

Test Plan:
- Single op: req0 valid, op=`ADD, a=5, b=7, tag=3, resp_ready=1 → req0_ready=1 that cycle; next cycle resp_valid=1, resp_data=12, resp_branch=1, resp_id=0, resp_tag=3.
- Contention RR: both valid for 4 cycles (req0 `SUB 10-4, req1 `XOR 0xF0^0x0F), resp_ready=1 → grants 0,1,0,1; responses 6, 0xFF alternating with matching ids. With ALU_ARB_FIXED_PRIO_EN: all four grants to 0.
- Backpressure: response pending, resp_ready=0 for 3 cycles, both valid → both readys 0, resp fields stable for 3 cycles; on resp_ready=1 a new grant and capture happen in the same cycle.
- Branch compare: req1 `BLT a=0xFFFFFFFF b=1 → resp_branch=1, resp_data=0, resp_id=1. Then `BLTU with the same operands → resp_branch=0.
- Reset mid-flight: response pending with resp_ready=0, assert rst 1 cycle → resp_valid=0 next cycle; with both valid afterwards, first grant is requester 0.
- Idle no-rotate: req1 accepted, 5 idle cycles, then both valid → requester 0 granted.
